sm3_expnd_core: RTL and testbench

//  SM3 message-expansion unit: the producer side of the Wj/W'j stream consumed by the compression core.

---
 rtl/sm3_expnd_if.sv | 37 +++
 rtl/sm3_expnd_core.sv | 124 ++++++++++++
 tb/tb_sm3_expnd_core.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm3_expnd_if.sv
// sm3_expnd_if
//  Bundles the word-input handshake and the (Wj, W'j) output stream of the
//  SM3 message-expansion core.
//  Signals:
//    inpt_data_i       32  message word, big-endian
//    inpt_vld_i         1  word valid
//    inpt_lst_i         1  word 15 belongs to the message's last block
//    inpt_rdy_o         1  core can accept a word
//    expnd_otpt_wj_o   32  Wj
//    expnd_otpt_wjj_o  32  W'j = Wj ^ Wj+4
//    expnd_otpt_vld_o   1  pair valid (no backpressure)
//    expnd_otpt_lst_o   1  final pair of the final block
//  Modports:
//    slave  - the expansion core
//    master - the word producer / stream consumer side
interface sm3_expnd_if;
  logic [31:0] inpt_data_i;
  logic        inpt_vld_i;
  logic        inpt_lst_i;
  logic        inpt_rdy_o;
  logic [31:0] expnd_otpt_wj_o;
  logic [31:0] expnd_otpt_wjj_o;
  logic        expnd_otpt_vld_o;
  logic        expnd_otpt_lst_o;

  modport slave (
    input  inpt_data_i, inpt_vld_i, inpt_lst_i,
    output inpt_rdy_o,
    output expnd_otpt_wj_o, expnd_otpt_wjj_o, expnd_otpt_vld_o, expnd_otpt_lst_o
  );

  modport master (
    output inpt_data_i, inpt_vld_i, inpt_lst_i,
    input  inpt_rdy_o,
    input  expnd_otpt_wj_o, expnd_otpt_wjj_o, expnd_otpt_vld_o, expnd_otpt_lst_o
  );
endinterface

// File: rtl/sm3_expnd_core.sv
// sm3_expnd_core
//  SM3 message expansion. Loads a 16-word block into a sliding window, then
//  streams 64 back-to-back (Wj, W'j) pairs, one per clock, generating new
//  window words on the fly. The final pair of a message's last block is
//  flagged so the compression core can release its digest.
//  Ports:
//    clk  in  clock
//    rst  in  synchronous, active-high reset
//    bus  sm3_expnd_if.slave  word input handshake + pair output stream
module sm3_expnd_core (
  input  logic            clk,
  input  logic            rst,
  sm3_expnd_if.slave      bus
);

  typedef enum logic {ST_LOAD, ST_EXPND} state_t;

  state_t             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [5:0]         rnd_q, rnd_d;
  logic [15:0][31:0]  win_q, win_d;
  logic               lst_flag_q, lst_flag_d;
  logic [31:0]        wj_q, wj_d;
  logic [31:0]        wjj_q, wjj_d;
  logic               vld_q, vld_d;
  logic               lst_q, lst_d;
  logic               xfer;

  function automatic logic [31:0] rotl7(input logic [31:0] x);
    return {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] rotl15(input logic [31:0] x);
    return {x[16:0], x[31:17]};
  endfunction

  function automatic logic [31:0] rotl23(input logic [31:0] x);
    return {x[8:0], x[31:9]};
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl15(x) ^ rotl23(x);
  endfunction

  // Ready is combinational so it is high in the very first cycle after reset
  // and forced low while reset is asserted.
  assign bus.inpt_rdy_o = (state_q == ST_LOAD) && !rst;
  assign xfer           = bus.inpt_vld_i && (state_q == ST_LOAD);

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rnd_d      = rnd_q;
    win_d      = win_q;
    lst_flag_d = lst_flag_q;
    wj_d       = wj_q;
    wjj_d      = wjj_q;
    vld_d      = 1'b0;
    lst_d      = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = bus.inpt_data_i;
          wcnt_d    = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            lst_flag_d = bus.inpt_lst_i;
            rnd_d      = 6'd0;
            state_d    = ST_EXPND;
          end
        end
      end
      ST_EXPND: begin
        wj_d  = win_q[0];
        wjj_d = win_q[0] ^ win_q[4];
        vld_d = 1'b1;
        lst_d = lst_flag_q && (rnd_q == 6'd63);
        // Window holds Wj..Wj+15; the new tail word is Wj+16. Words past W67
        // are generated during the last beats but never emitted.
        for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
        win_d[15] = p1(win_q[0] ^ win_q[7] ^ rotl15(win_q[13]))
                    ^ rotl7(win_q[3]) ^ win_q[10];
        rnd_d = rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          wcnt_d     = 4'd0;
          lst_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      wcnt_q     <= '0;
      rnd_q      <= '0;
      win_q      <= '0;
      lst_flag_q <= 1'b0;
      wj_q       <= '0;
      wjj_q      <= '0;
      vld_q      <= 1'b0;
      lst_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rnd_q      <= rnd_d;
      win_q      <= win_d;
      lst_flag_q <= lst_flag_d;
      wj_q       <= wj_d;
      wjj_q      <= wjj_d;
      vld_q      <= vld_d;
      lst_q      <= lst_d;
    end
  end

  assign bus.expnd_otpt_wj_o  = wj_q;
  assign bus.expnd_otpt_wjj_o = wjj_q;
  assign bus.expnd_otpt_vld_o = vld_q;
  assign bus.expnd_otpt_lst_o = lst_q;

endmodule

// File: tb/tb_sm3_expnd_core.sv
module tb_sm3_expnd_core;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] wexp_t [68];

  typedef struct {
    int          beat;
    logic [31:0] wj;
    logic [31:0] wjj;
    bit          chk_wjj;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] cap_wj  [64];
  logic [31:0] cap_wjj [64];
  logic        cap_lst [64];

  vec_t vecs [5];

  always #5 clk = ~clk;

  sm3_expnd_if bus ();

  sm3_expnd_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: textbook SM3 expansion over a full W[0..67] array.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1m(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  function automatic wexp_t expand(input blk_t m);
    wexp_t w;
    for (int j = 0; j < 16; j++) w[j] = m[j];
    for (int j = 16; j < 68; j++)
      w[j] = p1m(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Drives one block. Returns at the negedge right after word 15 was taken.
  task automatic send_block(input blk_t m, input bit lst, input bit gaps,
                            input bit hold, input string tag);
    int budget;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) chk($sformatf("%s idle_vld", tag), {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
      if (gaps) begin
        bus.inpt_vld_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      budget = 100;
      while (!bus.inpt_rdy_o && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        checks++;
        failures++;
        $display("FAIL %s rdy_timeout word=%0d", tag, i);
        return;
      end
      bus.inpt_data_i = m[i];
      bus.inpt_vld_i  = 1'b1;
      bus.inpt_lst_i  = (i == 15) ? lst : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.inpt_vld_i  = hold;
    bus.inpt_data_i = 32'hdead_beef;
    bus.inpt_lst_i  = hold;
  endtask

  // Checks latency, all 64 beats, and the return to idle. rst_at >= 0 aborts
  // the block with a reset after that beat.
  task automatic check_block(input wexp_t w, input bit lst, input string tag,
                             input int rst_at);
    bit seen;
    chk($sformatf("%s lat_vld", tag), {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
    chk($sformatf("%s lat_rdy", tag), {31'd0, bus.inpt_rdy_o}, 32'd0);
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      chk($sformatf("%s vld[%0d]", tag, j), {31'd0, bus.expnd_otpt_vld_o}, 32'd1);
      chk($sformatf("%s wj[%0d]", tag, j), bus.expnd_otpt_wj_o, w[j]);
      chk($sformatf("%s wjj[%0d]", tag, j), bus.expnd_otpt_wjj_o, w[j] ^ w[j+4]);
      chk($sformatf("%s lst[%0d]", tag, j), {31'd0, bus.expnd_otpt_lst_o},
          {31'd0, (lst && j == 63)});
      chk($sformatf("%s rdy[%0d]", tag, j), {31'd0, bus.inpt_rdy_o},
          {31'd0, (j == 63)});
      cap_wj[j]  = bus.expnd_otpt_wj_o;
      cap_wjj[j] = bus.expnd_otpt_wjj_o;
      cap_lst[j] = bus.expnd_otpt_lst_o;
      if (j == 62) bus.inpt_vld_i = 1'b0;
      if (j == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk($sformatf("%s abort_vld", tag), {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
        chk($sformatf("%s abort_lst", tag), {31'd0, bus.expnd_otpt_lst_o}, 32'd0);
        chk($sformatf("%s abort_rdy", tag), {31'd0, bus.inpt_rdy_o}, 32'd0);
        rst = 1'b0;
        bus.inpt_vld_i = 1'b0;
        seen = 1'b0;
        repeat (70) begin
          @(negedge clk);
          if (bus.expnd_otpt_vld_o || bus.expnd_otpt_lst_o) seen = 1'b1;
        end
        chk($sformatf("%s abort_quiet", tag), {31'd0, seen}, 32'd0);
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("%s end_vld", tag), {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
    chk($sformatf("%s end_lst", tag), {31'd0, bus.expnd_otpt_lst_o}, 32'd0);
  endtask

  task automatic table_check(input string tag);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s tbl_wj[%0d]", tag, vecs[k].beat), cap_wj[vecs[k].beat], vecs[k].wj);
      if (vecs[k].chk_wjj)
        chk($sformatf("%s tbl_wjj[%0d]", tag, vecs[k].beat), cap_wjj[vecs[k].beat], vecs[k].wjj);
    end
  endtask

  initial begin
    blk_t  abc, b1, b2;
    wexp_t wabc, w1, w2;

    vecs[0] = '{beat: 0,  wj: 32'h61626380, wjj: 32'h61626380, chk_wjj: 1'b1};
    vecs[1] = '{beat: 16, wj: 32'h9092e200, wjj: 32'h0,        chk_wjj: 1'b0};
    vecs[2] = '{beat: 18, wj: 32'h000c0606, wjj: 32'h0,        chk_wjj: 1'b0};
    vecs[3] = '{beat: 19, wj: 32'h719c70ed, wjj: 32'h0,        chk_wjj: 1'b0};
    vecs[4] = '{beat: 15, wj: 32'h00000018, wjj: 32'h0,        chk_wjj: 1'b0};

    for (int i = 0; i < 16; i++) abc[i] = 32'h0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    wabc = expand(abc);

    bus.inpt_data_i = '0;
    bus.inpt_vld_i  = 1'b0;
    bus.inpt_lst_i  = 1'b0;

    // Reset: everything low while asserted, ready right after release.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst rdy[%0d]", c), {31'd0, bus.inpt_rdy_o}, 32'd0);
      chk($sformatf("rst vld[%0d]", c), {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
      chk($sformatf("rst lst[%0d]", c), {31'd0, bus.expnd_otpt_lst_o}, 32'd0);
      chk($sformatf("rst wj[%0d]", c), bus.expnd_otpt_wj_o, 32'd0);
      chk($sformatf("rst wjj[%0d]", c), bus.expnd_otpt_wjj_o, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst rdy", {31'd0, bus.inpt_rdy_o}, 32'd1);

    // "abc" block, back-to-back words.
    send_block(abc, 1'b1, 1'b0, 1'b0, "abc");
    check_block(wabc, 1'b1, "abc", -1);
    table_check("abc");

    // Same block with random valid gaps.
    send_block(abc, 1'b1, 1'b1, 1'b0, "abc_gap");
    check_block(wabc, 1'b1, "abc_gap", -1);
    table_check("abc_gap");

    // Valid held high during expansion: junk must not be consumed.
    send_block(abc, 1'b0, 1'b0, 1'b1, "hold");
    check_block(wabc, 1'b0, "hold", -1);
    send_block(abc, 1'b1, 1'b0, 1'b0, "after_hold");
    check_block(wabc, 1'b1, "after_hold", -1);

    // Reset mid-expansion, then a clean reload.
    send_block(abc, 1'b1, 1'b0, 1'b0, "abort");
    check_block(wabc, 1'b1, "abort", 30);
    send_block(abc, 1'b1, 1'b0, 1'b0, "reload");
    check_block(wabc, 1'b1, "reload", -1);
    table_check("reload");

    // Random two-block message, then random single blocks.
    for (int i = 0; i < 16; i++) begin
      b1[i] = $urandom;
      b2[i] = $urandom;
    end
    w1 = expand(b1);
    w2 = expand(b2);
    send_block(b1, 1'b0, 1'b1, 1'b0, "msg_b1");
    check_block(w1, 1'b0, "msg_b1", -1);
    send_block(b2, 1'b1, 1'b1, 1'b0, "msg_b2");
    check_block(w2, 1'b1, "msg_b2", -1);

    for (int r = 0; r < 3; r++) begin
      bit l;
      for (int i = 0; i < 16; i++) b1[i] = $urandom;
      w1 = expand(b1);
      l  = 1'($urandom_range(0, 1));
      send_block(b1, l, 1'b1, 1'b0, $sformatf("rnd%0d", r));
      check_block(w1, l, $sformatf("rnd%0d", r), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
